// File: rtl/hazard_pkg.sv
// Shared decode constants, bypass encodings and producer classes for the hazard unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package hazard_pkg;

    // RV32 major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_R4     = 7'b1000011;

    // The whole R4 group (MADD/MSUB/NMSUB/NMADD) shares opcode bits [6:4]
    localparam logic [2:0] OPC_R4_HI  = 3'b100;

    // funct7 marking the M extension inside OP
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Per-port operand source select
    localparam logic [1:0] BYP_RF = 2'd0;
    localparam logic [1:0] BYP_X  = 2'd1;
    localparam logic [1:0] BYP_M  = 2'd2;
    localparam logic [1:0] BYP_W  = 2'd3;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_LOAD = 2'd2,
        CLS_MDU  = 2'd3
    } cls_t;

    function automatic logic is_r4(input logic [6:0] opc);
        return opc[6:4] == OPC_R4_HI;
    endfunction

endpackage

// File: rtl/hz_inst_decode.sv
// Extracts register operands, read enables, destination write enable and producer class.
// Latency: purely combinational.
// Backpressure: none; a pure function of the instruction word.
module hz_inst_decode
    import hazard_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rs3,
    output logic [4:0]  rd,
    output logic [2:0]  re,
    output logic        we,
    output logic [1:0]  cls
);

    logic [6:0] opc;
    logic       r4;
    logic       writes_op;
    logic       mdu;
    logic       unused_funct3;

    assign opc = inst[6:0];
    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];
    assign rs3 = inst[31:27];

    // funct3 does not influence hazards: all loads and all M ops are treated alike
    assign unused_funct3 = ^inst[14:12];

    // Operand usage, write enable and class from the opcode
    always_comb begin
        r4        = is_r4(opc);
        re        = 3'b000;
        re[0]     = (opc == OPC_OP)    || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
                    (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR) || r4;
        re[1]     = (opc == OPC_OP)    || (opc == OPC_STORE)  || (opc == OPC_BRANCH) || r4;
        re[2]     = r4;
        writes_op = (opc == OPC_OP)  || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
                    (opc == OPC_LUI) || (opc == OPC_AUIPC)  || (opc == OPC_JAL)  ||
                    (opc == OPC_JALR) || r4;
        we        = writes_op && (rd != 5'd0);
        mdu       = ((opc == OPC_OP) && (inst[31:25] == F7_MULDIV)) || r4;
        if (opc == OPC_LOAD)
            cls = CLS_LOAD;
        else if (mdu)
            cls = CLS_MDU;
        else if (we)
            cls = CLS_ALU;
        else
            cls = CLS_NONE;
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage stall and operand bypass control with a load/MDU scoreboard (optional perf counters: HAZARD_PERF_EN).
// Latency: stall_d_o and byp_sel_o combinational; scoreboard updates visible next cycle.
// Backpressure: stall_d_o holds D; pipe_stall_i freezes countdown and issue but not MDU completion.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int LD_LAT = 1,
    parameter int NRP    = 2,
    parameter int NREG   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_stall_i,
    input  logic [31:0]      inst_d_i,
    input  logic             valid_d_i,
    input  logic [31:0]      inst_x_i,
    input  logic [31:0]      inst_m_i,
    input  logic [31:0]      inst_w_i,
    input  logic             valid_x_i,
    input  logic             valid_m_i,
    input  logic             valid_w_i,
    input  logic             mdu_done_i,
    input  logic [4:0]       mdu_rd_i,
`ifdef HAZARD_PERF_EN
    output logic [31:0]      perf_stall_cnt_o,
    output logic [31:0]      perf_mdu_stall_o,
`endif
    output logic             stall_d_o,
    output logic [2*NRP-1:0] byp_sel_o
);

    localparam int CW = $clog2(LD_LAT + 1);

    // Per-stage decode, index 0 = D, 1 = X, 2 = M, 3 = W
    logic [31:0] inst_s [4];
    logic [4:0]  rs1_s  [4];
    logic [4:0]  rs2_s  [4];
    logic [4:0]  rs3_s  [4];
    logic [4:0]  rd_s   [4];
    logic [2:0]  re_s   [4];
    logic        we_s   [4];
    logic [1:0]  cls_s  [4];

    assign inst_s[0] = inst_d_i;
    assign inst_s[1] = inst_x_i;
    assign inst_s[2] = inst_m_i;
    assign inst_s[3] = inst_w_i;

    for (genvar s = 0; s < 4; s++) begin : g_dec
        hz_inst_decode u_dec (
            .inst (inst_s[s]),
            .rs1  (rs1_s[s]),
            .rs2  (rs2_s[s]),
            .rs3  (rs3_s[s]),
            .rd   (rd_s[s]),
            .re   (re_s[s]),
            .we   (we_s[s]),
            .cls  (cls_s[s])
        );
    end

    // Downstream stages only contribute their destination; their sources are irrelevant here
    logic unused_stage_src;
    assign unused_stage_src = ^{rs1_s[1], rs2_s[1], rs3_s[1], re_s[1],
                                rs1_s[2], rs2_s[2], rs3_s[2], re_s[2],
                                rs1_s[3], rs2_s[3], rs3_s[3], re_s[3]};

    logic [4:0] rs_d [3];
    assign rs_d[0] = rs1_s[0];
    assign rs_d[1] = rs2_s[0];
    assign rs_d[2] = rs3_s[0];

    // Scoreboard: load countdown and outstanding-MDU flag per register
    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:0] lng;

    logic raw_cnt;
    logic raw_lng;
    logic waw;
    logic strct;
    logic lng_hit;
    logic issue;

    // Hazard detection against the scoreboard for the instruction in D
    always_comb begin
        raw_cnt = 1'b0;
        raw_lng = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            if (re_s[0][p] && (rs_d[p] != 5'd0)) begin
                if (cnt[rs_d[p]] != '0)
                    raw_cnt = 1'b1;
                if (lng[rs_d[p]])
                    raw_lng = 1'b1;
            end
        end
        waw       = we_s[0] && lng[rd_s[0]];
        strct     = (cls_s[0] == CLS_MDU) && (|lng);
        lng_hit   = raw_lng || waw || strct;
        stall_d_o = valid_d_i && (raw_cnt || lng_hit);
    end

    assign issue = valid_d_i && !stall_d_o && !pipe_stall_i;

    // Operand bypass selection, nearest ALU/load producer wins; MDU results come via the RF
    always_comb begin
        byp_sel_o = '0;
        for (int p = 0; p < NRP; p++) begin
            if (valid_d_i && re_s[0][p] && (rs_d[p] != 5'd0)) begin
                if (valid_x_i && we_s[1] && (cls_s[1] == CLS_ALU) && (rd_s[1] == rs_d[p]))
                    byp_sel_o[2*p +: 2] = BYP_X;
                else if (valid_m_i && we_s[2] &&
                         ((cls_s[2] == CLS_LOAD) || (cls_s[2] == CLS_ALU)) &&
                         (rd_s[2] == rs_d[p]))
                    byp_sel_o[2*p +: 2] = BYP_M;
                else if (valid_w_i && we_s[3] && (cls_s[3] != CLS_MDU) && (rd_s[3] == rs_d[p]))
                    byp_sel_o[2*p +: 2] = BYP_W;
            end
        end
    end

    // Load countdown: decrement on every advance, a new load issue overrides the decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            if (!pipe_stall_i) begin
                for (int r = 0; r < NREG; r++)
                    if (cnt[r] != '0)
                        cnt[r] <= cnt[r] - CW'(1);
            end
            if (issue && (cls_s[0] == CLS_LOAD) && we_s[0])
                cnt[rd_s[0]] <= CW'(LD_LAT);
        end
    end

    // Outstanding MDU result flags; completion is honoured even while the pipe is frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            lng <= '0;
        end else begin
            if (mdu_done_i)
                lng[mdu_rd_i] <= 1'b0;
            if (issue && (cls_s[0] == CLS_MDU) && we_s[0])
                lng[rd_s[0]] <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Effective stall cycles (frozen cycles excluded), and the share due to MDU flags
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt_o <= '0;
            perf_mdu_stall_o <= '0;
        end else if (stall_d_o && !pipe_stall_i) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (lng_hit)
                perf_mdu_stall_o <= perf_mdu_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: bypass table plus load-use, MDU, WAW/structural and reset sequences.
// Two instances (LD_LAT=1 and LD_LAT=3) share stimulus; each sequence checks one of them.
// Inputs are driven 1 time unit after the rising edge and checked 1 unit later.
module tb_hazard_scoreboard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_stall_i;
    logic [31:0] inst_d_i, inst_x_i, inst_m_i, inst_w_i;
    logic        valid_d_i, valid_x_i, valid_m_i, valid_w_i;
    logic        mdu_done_i;
    logic [4:0]  mdu_rd_i;
    logic        stall1, stall3;
    logic [3:0]  sel1, sel3;
`ifdef HAZARD_PERF_EN
    logic [31:0] ps1, pm1, ps3, pm3;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.LD_LAT(1), .NRP(2), .NREG(32)) u1 (
        .clk(clk), .rst(rst), .pipe_stall_i(pipe_stall_i),
        .inst_d_i(inst_d_i), .valid_d_i(valid_d_i),
        .inst_x_i(inst_x_i), .inst_m_i(inst_m_i), .inst_w_i(inst_w_i),
        .valid_x_i(valid_x_i), .valid_m_i(valid_m_i), .valid_w_i(valid_w_i),
        .mdu_done_i(mdu_done_i), .mdu_rd_i(mdu_rd_i),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt_o(ps1), .perf_mdu_stall_o(pm1),
`endif
        .stall_d_o(stall1), .byp_sel_o(sel1)
    );

    hazard_scoreboard_unit #(.LD_LAT(3), .NRP(2), .NREG(32)) u3 (
        .clk(clk), .rst(rst), .pipe_stall_i(pipe_stall_i),
        .inst_d_i(inst_d_i), .valid_d_i(valid_d_i),
        .inst_x_i(inst_x_i), .inst_m_i(inst_m_i), .inst_w_i(inst_w_i),
        .valid_x_i(valid_x_i), .valid_m_i(valid_m_i), .valid_w_i(valid_w_i),
        .mdu_done_i(mdu_done_i), .mdu_rd_i(mdu_rd_i),
`ifdef HAZARD_PERF_EN
        .perf_stall_cnt_o(ps3), .perf_mdu_stall_o(pm3),
`endif
        .stall_d_o(stall3), .byp_sel_o(sel3)
    );

    // Instruction encoders
    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] add_i(input logic [4:0] rd, rs1, rs2);
        return r_op(7'b0000000, 3'b000, rd, rs1, rs2);
    endfunction
    function automatic logic [31:0] mul_i(input logic [4:0] rd, rs1, rs2);
        return r_op(7'b0000001, 3'b000, rd, rs1, rs2);
    endfunction
    function automatic logic [31:0] div_i(input logic [4:0] rd, rs1, rs2);
        return r_op(7'b0000001, 3'b100, rd, rs1, rs2);
    endfunction
    function automatic logic [31:0] lw_i(input logic [4:0] rd, rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] addi_i(input logic [4:0] rd, rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] lui_i(input logic [4:0] rd);
        return {20'h00001, rd, 7'b0110111};
    endfunction
    function automatic logic [31:0] sw_i(input logic [4:0] rs2, rs1, input logic [4:0] imm_lo);
        return {7'd0, rs2, rs1, 3'b010, imm_lo, 7'b0100011};
    endfunction
    function automatic logic [31:0] beq_i(input logic [4:0] rs1, rs2);
        return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic vd, input logic [31:0] x, input logic vx,
                         input logic [31:0] m, input logic vm, input logic [31:0] w, input logic vw);
        inst_d_i = d; valid_d_i = vd;
        inst_x_i = x; valid_x_i = vx;
        inst_m_i = m; valid_m_i = vm;
        inst_w_i = w; valid_w_i = vw;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pipe_stall_i = 1'b0;
        mdu_done_i = 1'b0;
        mdu_rd_i = 5'd0;
        inst_d_i = '0; inst_x_i = '0; inst_m_i = '0; inst_w_i = '0;
        valid_d_i = 1'b0; valid_x_i = 1'b0; valid_m_i = 1'b0; valid_w_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] d, x, m, w;
        logic [3:0]  v;          // {vd, vx, vm, vw}
        logic        exp_stall;
        logic [3:0]  exp_sel;    // {port1, port0}
    } vec_t;

    vec_t tbl [13];

    initial begin
        int scnt;

        // Combinational bypass vectors, scoreboard empty
        tbl[0]  = '{'0, '0, '0, '0, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{add_i(6,3,3), add_i(3,1,2), add_i(3,1,2), add_i(3,1,2), 4'b1111, 1'b0, 4'b0101};
        tbl[2]  = '{add_i(6,3,3), add_i(3,1,2), add_i(3,1,2), add_i(3,1,2), 4'b1011, 1'b0, 4'b1010};
        tbl[3]  = '{add_i(6,3,3), mul_i(3,1,2), lw_i(3,1), '0, 4'b1110, 1'b0, 4'b1010};
        tbl[4]  = '{add_i(6,3,3), mul_i(3,1,2), add_i(3,1,2), lw_i(3,1), 4'b1101, 1'b0, 4'b1111};
        tbl[5]  = '{add_i(6,0,0), add_i(3,1,2), add_i(0,1,2), '0, 4'b1110, 1'b0, 4'b0000};
        tbl[6]  = '{addi_i(6,3,12'd3), add_i(3,1,2), '0, '0, 4'b1100, 1'b0, 4'b0001};
        tbl[7]  = '{sw_i(3,4,5'd0), add_i(3,1,2), add_i(4,1,2), '0, 4'b1110, 1'b0, 4'b0110};
        tbl[8]  = '{add_i(6,3,3), add_i(3,1,2), '0, '0, 4'b0100, 1'b0, 4'b0000};
        tbl[9]  = '{add_i(6,3,3), lui_i(3), '0, '0, 4'b1100, 1'b0, 4'b0101};
        tbl[10] = '{beq_i(3,5), add_i(5,1,2), '0, add_i(3,1,2), 4'b1101, 1'b0, 4'b0111};
        tbl[11] = '{add_i(6,3,3), sw_i(1,2,5'd3), add_i(3,1,2), '0, 4'b1110, 1'b0, 4'b1010};
        tbl[12] = '{add_i(6,3,3), lw_i(3,1), '0, add_i(3,1,2), 4'b1101, 1'b0, 4'b1111};

        do_reset();
        #1;
        chk("reset_stall_u1", {31'd0, stall1}, 32'd0);
        chk("reset_sel_u1", {28'd0, sel1}, 32'd0);
        chk("reset_stall_u3", {31'd0, stall3}, 32'd0);
        chk("reset_sel_u3", {28'd0, sel3}, 32'd0);
`ifdef HAZARD_PERF_EN
        chk("reset_perf_u1", ps1, 32'd0);
        chk("reset_perf_mdu_u1", pm1, 32'd0);
`endif

        // Table pass with the pipe frozen so nothing issues
        pipe_stall_i = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].d, tbl[i].v[3], tbl[i].x, tbl[i].v[2],
                  tbl[i].m, tbl[i].v[1], tbl[i].w, tbl[i].v[0]);
            chk($sformatf("vec%0d_stall_u1", i), {31'd0, stall1}, {31'd0, tbl[i].exp_stall});
            chk($sformatf("vec%0d_sel_u1", i), {28'd0, sel1}, {28'd0, tbl[i].exp_sel});
            chk($sformatf("vec%0d_stall_u3", i), {31'd0, stall3}, {31'd0, tbl[i].exp_stall});
            chk($sformatf("vec%0d_sel_u3", i), {28'd0, sel3}, {28'd0, tbl[i].exp_sel});
        end

        // Load-use, LD_LAT=1: one stall cycle, then bypass from M
        do_reset();
        drive(lw_i(5,1), 1, '0, 0, '0, 0, '0, 0);
        chk("ldu1_c0_stall", {31'd0, stall1}, 32'd0);
        step();
        drive(add_i(6,5,1), 1, lw_i(5,1), 1, '0, 0, '0, 0);
        chk("ldu1_c1_stall", {31'd0, stall1}, 32'd1);
        chk("ldu1_c1_sel", {28'd0, sel1}, 32'd0);
        step();
        drive(add_i(6,5,1), 1, '0, 0, lw_i(5,1), 1, '0, 0);
        chk("ldu1_c2_stall", {31'd0, stall1}, 32'd0);
        chk("ldu1_c2_sel", {28'd0, sel1}, 32'h2);
        step();
        drive('0, 0, '0, 0, '0, 0, '0, 0);
        repeat (3) step();
        drive(add_i(6,5,1), 1, '0, 0, '0, 0, '0, 0);
        chk("ldu1_sat_stall", {31'd0, stall1}, 32'd0);

        // Load-use, LD_LAT=3 with two frozen cycles: five stall cycles, then bypass from W
        do_reset();
        drive(lw_i(5,1), 1, '0, 0, '0, 0, '0, 0);
        chk("ldu3_c0_stall", {31'd0, stall3}, 32'd0);
        step();
        scnt = 0;
        drive(add_i(6,5,1), 1, lw_i(5,1), 1, '0, 0, '0, 0);
        scnt += int'(stall3);
        step();
        pipe_stall_i = 1'b1;
        drive(add_i(6,5,1), 1, '0, 0, lw_i(5,1), 1, '0, 0);
        scnt += int'(stall3);
        step();
        scnt += int'(stall3);
        step();
        pipe_stall_i = 1'b0;
        #1;
        scnt += int'(stall3);
        step();
        drive(add_i(6,5,1), 1, '0, 0, '0, 0, lw_i(5,1), 1);
        scnt += int'(stall3);
        step();
        chk("ldu3_release_stall", {31'd0, stall3}, 32'd0);
        chk("ldu3_release_sel", {28'd0, sel3}, 32'h3);
        chk("ldu3_total_stalls", scnt, 32'd5);
`ifdef HAZARD_PERF_EN
        chk("ldu3_perf_stall", ps3, 32'd3);
        chk("ldu3_perf_mdu", pm3, 32'd0);
`endif

        // MDU dependency: stall until completion, release the cycle after mdu_done_i
        do_reset();
        drive(mul_i(7,1,2), 1, '0, 0, '0, 0, '0, 0);
        chk("mdu_c0_stall", {31'd0, stall1}, 32'd0);
        step();
        drive(add_i(8,7,7), 1, mul_i(7,1,2), 1, '0, 0, '0, 0);
        chk("mdu_c1_stall", {31'd0, stall1}, 32'd1);
        step();
        drive(add_i(8,7,7), 1, '0, 0, mul_i(7,1,2), 1, '0, 0);
        chk("mdu_c2_stall", {31'd0, stall1}, 32'd1);
        chk("mdu_c2_sel", {28'd0, sel1}, 32'd0);
        step();
        drive(add_i(8,7,7), 1, '0, 0, '0, 0, '0, 0);
        chk("mdu_c3_stall", {31'd0, stall1}, 32'd1);
        step();
        mdu_done_i = 1'b1;
        mdu_rd_i = 5'd7;
        #1;
        chk("mdu_done_cycle_stall", {31'd0, stall1}, 32'd1);
        step();
        mdu_done_i = 1'b0;
        #1;
        chk("mdu_release_stall", {31'd0, stall1}, 32'd0);
        chk("mdu_release_sel", {28'd0, sel1}, 32'd0);
`ifdef HAZARD_PERF_EN
        chk("mdu_perf_stall", ps1, 32'd4);
        chk("mdu_perf_mdu", pm1, 32'd4);
`endif

        // WAW and structural hazards with lng[9] set; completion while frozen
        do_reset();
        drive(mul_i(9,1,2), 1, '0, 0, '0, 0, '0, 0);
        step();
        pipe_stall_i = 1'b1;
        drive(addi_i(9,1,12'd1), 1, '0, 0, '0, 0, '0, 0);
        chk("waw_stall", {31'd0, stall1}, 32'd1);
        drive(div_i(4,1,2), 1, '0, 0, '0, 0, '0, 0);
        chk("struct_stall", {31'd0, stall1}, 32'd1);
        drive(add_i(10,1,2), 1, '0, 0, '0, 0, '0, 0);
        chk("indep_nostall", {31'd0, stall1}, 32'd0);
        mdu_done_i = 1'b1;
        mdu_rd_i = 5'd9;
        step();
        mdu_done_i = 1'b0;
        drive(div_i(4,1,2), 1, '0, 0, '0, 0, '0, 0);
        chk("struct_cleared_frozen", {31'd0, stall1}, 32'd0);
        pipe_stall_i = 1'b0;

        // Reset discards a pending load countdown and an outstanding MDU flag
        do_reset();
        drive(lw_i(5,1), 1, '0, 0, '0, 0, '0, 0);
        step();
        drive(mul_i(7,1,2), 1, '0, 0, '0, 0, '0, 0);
        step();
        drive(add_i(6,5,7), 1, '0, 0, '0, 0, '0, 0);
        chk("pre_reset_stall_u3", {31'd0, stall3}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("post_reset_stall_u3", {31'd0, stall3}, 32'd0);
        chk("post_reset_stall_u1", {31'd0, stall1}, 32'd0);
`ifdef HAZARD_PERF_EN
        chk("post_reset_perf_u3", ps3, 32'd0);
        chk("post_reset_perf_mdu_u3", pm3, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
